// File: rtl/lsu_mem_master.sv
// Load/store bus initiator: byte/half/word requests become lane-enabled word beats, split across words when needed.
// Latency 2 cycles aligned, 3 split, +1 per beat for RD_LAT=1 loads; ready only in IDLE, response has no backpressure.
module lsu_mem_master #(
    parameter int ADDR_W   = 13,
    parameter int RD_LAT   = 0,
    parameter int SPLIT_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_write_o,
    output logic [3:0]        mem_be_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);
    typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

    state_t              state_q;
    logic                write_q, uns_q, err_q;
    logic [1:0]          size_q, off_q;
    logic [6:0]          mask_q;
    logic [63:0]         wide_q;
    logic [31:0]         b0_q, b1_q;
    logic                mem_write_q;
    logic [3:0]          mem_be_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_data_q;
    logic                rsp_valid_q, rsp_err_q;
    logic [31:0]         rsp_rdata_q;

    logic [3:0]          size_mask_d;
    logic [6:0]          mask_d;
    logic [63:0]         wide_d;
    logic                err_d, load_wait_d, adv0_d, adv1_d;
    logic [31:0]         shifted_d, rdata_d;

    always_comb begin
        size_mask_d = 4'b0000;
        case (req_size_i)
            2'b00:   size_mask_d = 4'b0001;
            2'b01:   size_mask_d = 4'b0011;
            2'b10:   size_mask_d = 4'b1111;
            default: size_mask_d = 4'b0000;
        endcase
    end

    // Lanes above bit 3 belong to the next word; their presence is what forces a second beat.
    assign mask_d      = {3'b000, size_mask_d} << req_addr_i[1:0];
    assign wide_d      = {32'h0, req_wdata_i} << {req_addr_i[1:0], 3'b000};
    assign err_d       = (req_size_i == 2'b11) || (SPLIT_EN == 0 && mask_d[6:4] != 3'b000);
    assign load_wait_d = !write_q && (RD_LAT != 0);
    assign adv0_d      = (state_q == BEAT0 && !load_wait_d) || state_q == WAIT0;
    assign adv1_d      = (state_q == BEAT1 && !load_wait_d) || state_q == WAIT1;
    assign shifted_d   = 32'({b1_q, b0_q} >> {off_q, 3'b000});

    always_comb begin
        rdata_d = 32'h0;
        case (size_q)
            2'b00:   rdata_d = {{24{~uns_q & shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   rdata_d = {{16{~uns_q & shifted_d[15]}}, shifted_d[15:0]};
            2'b10:   rdata_d = shifted_d;
            default: rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            mask_q      <= 7'h0;
            wide_q      <= 64'h0;
            b0_q        <= 32'h0;
            b1_q        <= 32'h0;
            mem_write_q <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= '0;
            mem_data_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        uns_q   <= req_unsigned_i;
                        size_q  <= req_size_i;
                        off_q   <= req_addr_i[1:0];
                        mask_q  <= mask_d;
                        wide_q  <= wide_d;
                        err_q   <= err_d;
                        if (err_d) begin
                            state_q <= RESP;
                        end else begin
                            state_q     <= BEAT0;
                            mem_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= mask_d[3:0];
                            mem_data_q  <= wide_d[31:0];
                            mem_write_q <= req_write_i;
                        end
                    end
                end
                BEAT0, WAIT0: begin
                    if (adv0_d) begin
                        b0_q <= mem_data_i;
                        if (mask_q[6:4] != 3'b000) begin
                            state_q     <= BEAT1;
                            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
                            mem_be_q    <= {1'b0, mask_q[6:4]};
                            mem_data_q  <= wide_q[63:32];
                            mem_write_q <= write_q;
                        end else begin
                            state_q     <= RESP;
                            mem_be_q    <= 4'h0;
                            mem_write_q <= 1'b0;
                        end
                    end else begin
                        state_q     <= WAIT0;
                        mem_write_q <= 1'b0;
                    end
                end
                BEAT1, WAIT1: begin
                    if (adv1_d) begin
                        b1_q        <= mem_data_i;
                        state_q     <= RESP;
                        mem_be_q    <= 4'h0;
                        mem_write_q <= 1'b0;
                    end else begin
                        state_q     <= WAIT1;
                        mem_write_q <= 1'b0;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_rdata_q <= (err_q || write_q) ? 32'h0 : rdata_d;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign mem_write_o  = mem_write_q & ~rst_i;
    assign mem_be_sel_o = mem_be_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: instance A is split-capable with combinational memory,
// instance B has no split and a one-cycle registered memory.
module tb_lsu_mem_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [12:0] req_addr = 13'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        a_ready, a_rsp_valid, a_rsp_err, a_mem_write;
    logic [31:0] a_rsp_rdata, a_mem_data, a_mem_rd;
    logic [3:0]  a_mem_be;
    logic [12:0] a_mem_addr;
    logic        b_ready, b_rsp_valid, b_rsp_err, b_mem_write;
    logic [31:0] b_rsp_rdata, b_mem_data, b_mem_rd;
    logic [3:0]  b_mem_be;
    logic [12:0] b_mem_addr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int b_beats = 0;

    typedef struct packed {
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        wr;
    } beat_t;
    beat_t beats[$];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem_a [8192];
    logic [7:0] mem_b [8192];

    lsu_mem_master #(.ADDR_W(13), .RD_LAT(0), .SPLIT_EN(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_a), .req_ready_o(a_ready),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(a_rsp_valid),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err), .mem_write_o(a_mem_write),
        .mem_be_sel_o(a_mem_be), .mem_addr_o(a_mem_addr), .mem_data_o(a_mem_data),
        .mem_data_i(a_mem_rd)
    );

    lsu_mem_master #(.ADDR_W(13), .RD_LAT(1), .SPLIT_EN(0)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_b), .req_ready_o(b_ready),
        .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(b_rsp_valid),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err), .mem_write_o(b_mem_write),
        .mem_be_sel_o(b_mem_be), .mem_addr_o(b_mem_addr), .mem_data_o(b_mem_data),
        .mem_data_i(b_mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8192; i++) begin
                mem_a[i] <= 8'h00;
                mem_b[i] <= 8'h00;
            end
        end else begin
            if (a_mem_write)
                for (int l = 0; l < 4; l++)
                    if (a_mem_be[l]) mem_a[a_mem_addr + 13'(l)] <= a_mem_data[8*l +: 8];
            if (b_mem_write)
                for (int l = 0; l < 4; l++)
                    if (b_mem_be[l]) mem_b[b_mem_addr + 13'(l)] <= b_mem_data[8*l +: 8];
        end
        b_mem_rd <= {mem_b[b_mem_addr + 13'd3], mem_b[b_mem_addr + 13'd2],
                     mem_b[b_mem_addr + 13'd1], mem_b[b_mem_addr]};
    end

    assign a_mem_rd = {mem_a[a_mem_addr + 13'd3], mem_a[a_mem_addr + 13'd2],
                       mem_a[a_mem_addr + 13'd1], mem_a[a_mem_addr]};

    always @(negedge clk) begin
        if (a_mem_be != 4'h0) beats.push_back({a_mem_addr, a_mem_be, a_mem_data, a_mem_write});
        if (b_mem_be != 4'h0) b_beats <= b_beats + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        lanes = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic check_beat(input int idx, input logic [12:0] addr, input logic [3:0] be,
                              input logic [31:0] data, input logic wr);
        if (idx < beats.size()) begin
            chk($sformatf("beat%0d_addr", idx), 32'(beats[idx].addr), 32'(addr));
            chk($sformatf("beat%0d_be", idx), 32'(beats[idx].be), 32'(be));
            chk($sformatf("beat%0d_data", idx), beats[idx].data & lanes(be), data & lanes(be));
            chk($sformatf("beat%0d_wr", idx), 32'(beats[idx].wr), 32'(wr));
        end else begin
            chk($sformatf("beat%0d_present", idx), 32'(0), 32'(1));
        end
    endtask

    // Called at a negedge with both DUTs idle; returns at a negedge.
    task automatic do_req(input bit alt, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [12:0] addr, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        exp_t e, got_e;
        int   t_acc;
        bit   got;
        beats.delete();
        b_beats = 0;
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        if (alt) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        chk("req_ready", 32'(alt ? b_ready : a_ready), 32'(1));
        e.err = exp_err; e.rdata = exp_rd; e.lat = exp_lat;
        sb.push_back(e);
        @(posedge clk);
        #1 t_acc = cyc;
        @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_addr = 13'($urandom); req_wdata = $urandom; req_size = 2'($urandom);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (alt ? b_rsp_valid : a_rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rsp_seen", 32'(got), 32'(1));
        got_e = sb.pop_front();
        if (got) begin
            chk("rsp_err", 32'(alt ? b_rsp_err : a_rsp_err), 32'(got_e.err));
            chk("rsp_rdata", alt ? b_rsp_rdata : a_rsp_rdata, got_e.rdata);
            chk("rsp_latency", 32'(cyc - t_acc), 32'(got_e.lat));
            @(negedge clk);
            chk("rsp_one_cycle", 32'(alt ? b_rsp_valid : a_rsp_valid), 32'(0));
        end
    endtask

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'(0));
        chk("rst_rsp_err", 32'(a_rsp_err), 32'(0));
        chk("rst_rsp_rdata", a_rsp_rdata, 32'h0);
        chk("rst_mem_write", 32'(a_mem_write), 32'(0));
        chk("rst_mem_be", 32'(a_mem_be), 32'(0));
        chk("rst_mem_addr", 32'(a_mem_addr), 32'(0));
        chk("rst_mem_data", a_mem_data, 32'h0);
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(a_ready), 32'(1));

        // Aligned word store and load.
        do_req(0, 1, 2'b10, 0, 13'h0100, 32'hDEADBEEF, 0, 32'h0, 2);
        chk("w_store_beats", 32'(beats.size()), 32'(1));
        check_beat(0, 13'h0100, 4'hF, 32'hDEADBEEF, 1);
        do_req(0, 0, 2'b10, 0, 13'h0100, 32'h0, 0, 32'hDEADBEEF, 2);
        check_beat(0, 13'h0100, 4'hF, 32'h0, 0);

        // Sub-word loads with extension.
        do_req(0, 1, 2'b10, 0, 13'h0100, 32'h80FF7F01, 0, 32'h0, 2);
        do_req(0, 0, 2'b00, 0, 13'h0103, 32'h0, 0, 32'hFFFFFF80, 2);
        check_beat(0, 13'h0100, 4'h8, 32'h0, 0);
        do_req(0, 0, 2'b00, 1, 13'h0103, 32'h0, 0, 32'h00000080, 2);
        do_req(0, 0, 2'b01, 0, 13'h0100, 32'h0, 0, 32'h00007F01, 2);
        do_req(0, 0, 2'b01, 0, 13'h0102, 32'h0, 0, 32'hFFFF80FF, 2);
        do_req(0, 0, 2'b00, 0, 13'h0101, 32'h0, 0, 32'h0000007F, 2);

        // Misaligned word store splits into two beats.
        do_req(0, 1, 2'b10, 0, 13'h0102, 32'h11223344, 0, 32'h0, 3);
        chk("split_store_beats", 32'(beats.size()), 32'(2));
        check_beat(0, 13'h0100, 4'hC, 32'h33440000, 1);
        check_beat(1, 13'h0104, 4'h3, 32'h00001122, 1);
        do_req(0, 0, 2'b10, 0, 13'h0102, 32'h0, 0, 32'h11223344, 3);

        // Half store at the top of memory wraps to address 0.
        do_req(0, 1, 2'b01, 0, 13'h1FFF, 32'h0000ABCD, 0, 32'h0, 3);
        check_beat(0, 13'h1FFC, 4'h8, 32'hCD000000, 1);
        check_beat(1, 13'h0000, 4'h1, 32'h000000AB, 1);
        do_req(0, 0, 2'b01, 0, 13'h1FFF, 32'h0, 0, 32'hFFFFABCD, 3);

        // Illegal size; misaligned without split support.
        do_req(0, 0, 2'b11, 0, 13'h0100, 32'h0, 1, 32'h0, 1);
        chk("illegal_no_beats", 32'(beats.size()), 32'(0));
        do_req(1, 0, 2'b10, 0, 13'h0001, 32'h0, 1, 32'h0, 1);
        chk("nosplit_no_beats", 32'(b_beats), 32'(0));

        // Registered-read memory adds a wait per load beat.
        do_req(1, 1, 2'b10, 0, 13'h0100, 32'hCAFEF00D, 0, 32'h0, 2);
        do_req(1, 0, 2'b10, 0, 13'h0100, 32'h0, 0, 32'hCAFEF00D, 3);

        // Reset during the second beat of a split store.
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 13'h0201; req_wdata = 32'h55667788; req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        chk("rstmid_beat0_be", 32'(a_mem_be), 32'hE);
        chk("rstmid_beat0_wr", 32'(a_mem_write), 32'(1));
        @(negedge clk);
        chk("rstmid_beat1_be", 32'(a_mem_be), 32'h1);
        rst = 1'b1;
        #1 chk("rstmid_write_gated", 32'(a_mem_write), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ready", 32'(a_ready), 32'(1));
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (a_rsp_valid) pulses++;
            @(negedge clk);
        end
        chk("rstmid_no_rsp", 32'(pulses), 32'(0));
        do_req(0, 0, 2'b00, 1, 13'h0201, 32'h0, 0, 32'h00000088, 2);
        do_req(0, 0, 2'b00, 1, 13'h0203, 32'h0, 0, 32'h00000066, 2);
        do_req(0, 0, 2'b00, 1, 13'h0204, 32'h0, 0, 32'h00000000, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end
endmodule
